// File: rtl/uart_rx_kbd.sv
// UART 8N1 receiver feeding a memory-mapped keyboard data/status register pair.
// A received byte is offered to KBDR/KBSR only when the keyboard ready flag
// (KBSR[15]) is clear. Otherwise it is reported as an overrun. A bad stop bit
// is reported as a framing error.
module uart_rx_kbd #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_Serial,
    input  logic [15:0] KBSR,
    output logic        LD_KBDR_EXT,
    output logic [15:0] KBDR_EXT,
    output logic        LD_KBSR_EXT,
    output logic [15:0] KBSR_EXT,
    output logic [7:0]  o_Rx_Byte,
    output logic        o_Overrun,
    output logic        o_Frame_Err
);

    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic        r_rx_meta;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_stop_ok;
    logic [7:0]  r_rx_byte;

    logic        w_done;
    logic        w_load;
    logic [7:0]  w_byte_out;
    logic        w_unused_kbsr;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM: mid-bit sampling of start, 8 data bits (LSB first) and stop.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_stop_ok <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!r_rx_s)
                        r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        // A line back high at mid-start is a glitch, not a frame.
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        if (r_idx == 3'd7) begin
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt     <= '0;
                        r_stop_ok <= r_rx_s;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    // Single report cycle; IDLE immediately re-arms for a back-to-back frame.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holds the last byte handed to the keyboard data register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            r_rx_byte <= '0;
        else if (w_load)
            r_rx_byte <= r_shift;
    end

    // DONE-cycle decode. KBSR is only looked at here, so its value
    // during the rest of the frame never matters.
    always_comb begin
        w_done      = (r_state == S_DONE);
        w_load      = w_done && r_stop_ok && !KBSR[15];
        LD_KBDR_EXT = w_load;
        LD_KBSR_EXT = w_load;
        o_Overrun   = w_done && r_stop_ok && KBSR[15];
        o_Frame_Err = w_done && !r_stop_ok;
        // The new byte is presented in the same cycle as the load strobe.
        w_byte_out  = w_load ? r_shift : r_rx_byte;
        KBDR_EXT    = {8'h00, w_byte_out};
        o_Rx_Byte   = w_byte_out;
        KBSR_EXT    = 16'h8000;
    end

    // Only the ready flag of KBSR is meaningful to this block.
    assign w_unused_kbsr = ^KBSR[14:0];

endmodule

// File: tb/tb_uart_rx_kbd.sv
// Directed bench for uart_rx_kbd at 87 clocks per bit.
module tb_uart_rx_kbd;

    localparam int CPB = 87;

    logic        clk;
    logic        i_Reset;
    logic        i_Rx_Serial;
    logic [15:0] KBSR;
    logic        LD_KBDR_EXT;
    logic [15:0] KBDR_EXT;
    logic        LD_KBSR_EXT;
    logic [15:0] KBSR_EXT;
    logic [7:0]  o_Rx_Byte;
    logic        o_Overrun;
    logic        o_Frame_Err;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cyc = 0;
    int          n_ld = 0;
    int          n_lds = 0;
    int          n_ovr = 0;
    int          n_fe = 0;
    int          n_viol = 0;
    int          n_kbsr_bad = 0;
    int          last_ld_cyc = 0;
    logic [15:0] ld_log [0:15];
    logic        prev_any = 1'b0;

    // Snapshots
    int b_ld, b_lds, b_ovr, b_fe;
    int start_cyc;

    uart_rx_kbd #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .KBSR        (KBSR),
        .LD_KBDR_EXT (LD_KBDR_EXT),
        .KBDR_EXT    (KBDR_EXT),
        .LD_KBSR_EXT (LD_KBSR_EXT),
        .KBSR_EXT    (KBSR_EXT),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Overrun   (o_Overrun),
        .o_Frame_Err (o_Frame_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample strobes away from the active edge.
    always @(negedge clk) begin
        if (LD_KBDR_EXT) begin
            ld_log[n_ld % 16] <= KBDR_EXT;
            n_ld        <= n_ld + 1;
            last_ld_cyc <= cyc;
        end
        if (LD_KBSR_EXT) n_lds <= n_lds + 1;
        if (o_Overrun)   n_ovr <= n_ovr + 1;
        if (o_Frame_Err) n_fe  <= n_fe + 1;
        if ((LD_KBDR_EXT != LD_KBSR_EXT) ||
            (int'(LD_KBDR_EXT) + int'(o_Overrun) + int'(o_Frame_Err) > 1) ||
            (prev_any && (LD_KBDR_EXT || LD_KBSR_EXT || o_Overrun || o_Frame_Err)))
            n_viol <= n_viol + 1;
        prev_any <= LD_KBDR_EXT || LD_KBSR_EXT || o_Overrun || o_Frame_Err;
        if (KBSR_EXT !== 16'h8000) n_kbsr_bad <= n_kbsr_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        b_ld  = n_ld;
        b_lds = n_lds;
        b_ovr = n_ovr;
        b_fe  = n_fe;
    endtask

    task automatic idle(input int n);
        i_Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called just after a falling clock edge; drives one full 8N1 frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, output int sc);
        i_Rx_Serial = 1'b0;
        sc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_Rx_Serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        i_Rx_Serial = stop_v;
        repeat (CPB) @(negedge clk);
        i_Rx_Serial = 1'b1;
    endtask

    initial begin
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        KBSR        = 16'h0000;
        repeat (4) @(negedge clk);
        check("rst_kbsr_ext", 32'(KBSR_EXT), 32'h8000);
        check("rst_ld", 32'({LD_KBDR_EXT, LD_KBSR_EXT, o_Overrun, o_Frame_Err}), 32'h0);
        i_Reset = 1'b0;
        idle(10);
        check("rst_kbdr_ext", 32'(KBDR_EXT), 32'h0000);
        check("rst_rx_byte", 32'(o_Rx_Byte), 32'h00);

        // Scenario 1: 0x41, ready flag clear. Strobe 830 cycles after the start edge.
        snap();
        send_frame(8'h41, 1'b1, start_cyc);
        idle(20);
        check("s1_ld_cnt", 32'(n_ld - b_ld), 32'd1);
        check("s1_lds_cnt", 32'(n_lds - b_lds), 32'd1);
        check("s1_kbdr", 32'(ld_log[b_ld % 16]), 32'h0041);
        check("s1_latency", 32'(last_ld_cyc - start_cyc), 32'd830);
        check("s1_rx_byte", 32'(o_Rx_Byte), 32'h41);
        check("s1_no_err", 32'((n_ovr - b_ovr) + (n_fe - b_fe)), 32'd0);

        // Scenario 2: ready flag set -> overrun, data held.
        KBSR = 16'h8000;
        snap();
        send_frame(8'h5A, 1'b1, start_cyc);
        idle(20);
        KBSR = 16'h0000;
        check("s2_ovr_cnt", 32'(n_ovr - b_ovr), 32'd1);
        check("s2_no_ld", 32'((n_ld - b_ld) + (n_lds - b_lds)), 32'd0);
        check("s2_kbdr_hold", 32'(KBDR_EXT), 32'h0041);
        check("s2_rx_byte_hold", 32'(o_Rx_Byte), 32'h41);

        // Scenario 3: stop bit low -> framing error only.
        snap();
        send_frame(8'h33, 1'b0, start_cyc);
        idle(200);
        check("s3_fe_cnt", 32'(n_fe - b_fe), 32'd1);
        check("s3_no_ld", 32'((n_ld - b_ld) + (n_ovr - b_ovr)), 32'd0);
        check("s3_rx_byte_hold", 32'(o_Rx_Byte), 32'h41);

        // Scenario 4: 20-clock glitch, then a real frame must still be received.
        snap();
        i_Rx_Serial = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        check("s4_glitch_quiet", 32'((n_ld - b_ld) + (n_ovr - b_ovr) + (n_fe - b_fe)), 32'd0);
        snap();
        send_frame(8'h96, 1'b1, start_cyc);
        idle(20);
        check("s4_after_kbdr", 32'(ld_log[b_ld % 16]), 32'h0096);

        // Scenario 5: back-to-back 0x00 then 0xFF.
        snap();
        send_frame(8'h00, 1'b1, start_cyc);
        send_frame(8'hFF, 1'b1, start_cyc);
        idle(20);
        check("s5_ld_cnt", 32'(n_ld - b_ld), 32'd2);
        check("s5_kbdr0", 32'(ld_log[b_ld % 16]), 32'h0000);
        check("s5_kbdr1", 32'(ld_log[(b_ld + 1) % 16]), 32'h00FF);
        check("s5_rx_byte", 32'(o_Rx_Byte), 32'hFF);

        // Scenario 6: reset during bit 4 of 0xA5, then 0x3C.
        snap();
        i_Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            i_Rx_Serial = 1'(8'hA5 >> i);
            repeat (i == 4 ? CPB / 2 : CPB) @(negedge clk);
        end
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        check("s6_rst_kbdr", 32'(KBDR_EXT), 32'h0000);
        i_Reset = 1'b0;
        idle(3 * CPB);
        check("s6_abort_quiet", 32'((n_ld - b_ld) + (n_ovr - b_ovr) + (n_fe - b_fe)), 32'd0);
        send_frame(8'h3C, 1'b1, start_cyc);
        idle(20);
        check("s6_ld_cnt", 32'(n_ld - b_ld), 32'd1);
        check("s6_kbdr", 32'(ld_log[b_ld % 16]), 32'h003C);
        check("s6_no_err", 32'((n_ovr - b_ovr) + (n_fe - b_fe)), 32'd0);

        // Whole-run properties.
        check("strobe_exclusive", 32'(n_viol), 32'd0);
        check("kbsr_ext_const", 32'(n_kbsr_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
